// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for data_mem_arbiter: FSM state encoding, default word
// width and the legal range of the memory read latency.
package data_mem_arbiter_pkg;

  localparam int WORD_W      = 16;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;
  localparam int LAT_CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  // Out-of-range latencies are pulled back into the supported window.
  function automatic int clamp_lat(input int lat);
    if (lat < MEM_LAT_MIN) begin
      return MEM_LAT_MIN;
    end else if (lat > MEM_LAT_MAX) begin
      return MEM_LAT_MAX;
    end else begin
      return lat;
    end
  endfunction

endpackage

// File: rtl/data_mem_arbiter_arb_pick.sv
// arb_pick: two-way winner selection. On contention the requester that did not
// win last time is chosen; a constant last_grant of 1 gives fixed priority to 0.
module arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: serialises two requesters onto one single-port data memory.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default favours requester 0.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = WORD_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);

  localparam int                   LAT      = clamp_lat(MEM_LAT);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT);

  arb_state_t           state;
  arb_state_t           state_nx;
  logic [LAT_CNT_W-1:0] cnt;
  logic [LAT_CNT_W-1:0] cnt_nx;
  logic                 grant;
  logic                 capture;
  logic                 cmd_we;
  logic                 last_grant;
  logic                 pick_valid;
  logic                 pick_winner;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= pick_winner;
    end else begin
      last_grant <= last_grant;
    end
  end
`else
  assign last_grant = 1'b1;
`endif

  always_comb begin
    if (pick_winner) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end else begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state; the counter reaching 1 marks the cycle mem_rdata is valid.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant    = 1'b1;
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        cnt_nx   = LAT_LOAD;
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == LAT_CNT_W'(1)) begin
          capture  = ~cmd_we;
          state_nx = ACK;
        end else begin
          cnt_nx   = cnt - LAT_CNT_W'(1);
          state_nx = WAIT;
        end
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      gnt_id    <= 1'b1;
      cmd_we    <= 1'b0;
    end else begin
      mem_en <= grant;
      mem_we <= grant & sel_we;
      busy   <= (state_nx != IDLE);
      ack0   <= (state_nx == ACK) & ~gnt_id;
      ack1   <= (state_nx == ACK) & gnt_id;
      if (capture) begin
        rdata <= mem_rdata;
      end else begin
        rdata <= rdata;
      end
      if (grant) begin
        gnt_id    <= pick_winner;
        cmd_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end else begin
        gnt_id    <= gnt_id;
        cmd_we    <= cmd_we;
        mem_addr  <= mem_addr;
        mem_wdata <= mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two instances (MEM_LAT 1 and 3) driven by random
// requesters and checked every cycle against a transaction-level model.
module tb_data_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req0, req1, we0, we1;
  logic [15:0] addr0 [2];
  logic [15:0] addr1 [2];
  logic [15:0] wdata0 [2];
  logic [15:0] wdata1 [2];
  logic [15:0] mem_rdata [2];
  logic [1:0]  ack0, ack1, mem_en, mem_we, busy, gnt_id;
  logic [15:0] rdata [2];
  logic [15:0] mem_addr [2];
  logic [15:0] mem_wdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(g == 0 ? 1 : 3)) dut (
      .clk(clk), .reset(reset),
      .req0(req0[g]), .req1(req1[g]), .we0(we0[g]), .we1(we1[g]),
      .addr0(addr0[g]), .addr1(addr1[g]), .wdata0(wdata0[g]), .wdata1(wdata1[g]),
      .ack0(ack0[g]), .ack1(ack1[g]), .rdata(rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g]), .gnt_id(gnt_id[g])
    );
  end

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n = 0;

  // requester side: active command, queued directed command, dropped-while-owner
  bit          act [2][2];
  bit          want [2][2];
  bit          hold [2][2];
  bit          c_we [2][2];
  logic [15:0] c_adr [2][2];
  logic [15:0] c_dat [2][2];
  bit          w_we [2][2];
  logic [15:0] w_adr [2][2];
  logic [15:0] w_dat [2][2];
  int          p_new = 0;
  int          p_drop = 0;
  bit          hammer = 1'b0;
  bit          rec_on = 1'b0;
  int          rec_q0 [$];
  int          rec_q1 [$];

  // reference model: one transaction in flight, timed from its grant
  bit          pend [2];
  int          own [2];
  int          t_iss [2];
  bit          m_we [2];
  logic [15:0] m_adr [2];
  logic [15:0] m_dat [2];
  logic [15:0] m_rd [2];
  bit          m_gid [2];
  bit          m_last [2];
  logic [15:0] ref_mem [2][256];

  // memory environment
  logic [15:0] env_mem [2][256];
  int          env_en [2];
  logic [15:0] env_adr [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int tack(input int i);
    return t_iss[i] + lat_of(i) + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; m_gid[i] = 1'b1; m_last[i] = 1'b1; m_rd[i] = 16'h0000;
      env_en[i] = -100;
      for (int p = 0; p < 2; p++) begin
        act[i][p] = 1'b0; want[i][p] = 1'b0; hold[i][p] = 1'b0;
        c_we[i][p] = 1'b0; c_adr[i][p] = 16'h0000; c_dat[i][p] = 16'h0000;
      end
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 2; i++) begin
      req0[i] = act[i][0]; we0[i] = c_we[i][0]; addr0[i] = c_adr[i][0]; wdata0[i] = c_dat[i][0];
      req1[i] = act[i][1]; we1[i] = c_we[i][1]; addr1[i] = c_adr[i][1]; wdata1[i] = c_dat[i][1];
    end
  endtask

  task automatic check_cycle(input int i);
    bit live, en_e, ack_e;
    live  = pend[i] && (n <= tack(i));
    en_e  = live && (n == t_iss[i]);
    ack_e = live && (n == tack(i));
    if (ack_e) begin
      if (m_we[i]) ref_mem[i][m_adr[i][7:0]] = m_dat[i];
      else         m_rd[i] = ref_mem[i][m_adr[i][7:0]];
    end
    chk($sformatf("u%0d mem_en", i), mem_en[i], en_e);
    chk($sformatf("u%0d mem_we", i), mem_we[i], en_e && m_we[i]);
    chk($sformatf("u%0d busy", i), busy[i], live && (n >= t_iss[i]));
    chk($sformatf("u%0d ack0", i), ack0[i], ack_e && (own[i] == 0));
    chk($sformatf("u%0d ack1", i), ack1[i], ack_e && (own[i] == 1));
    chk($sformatf("u%0d rdata", i), rdata[i], m_rd[i]);
    chk($sformatf("u%0d gnt_id", i), gnt_id[i], m_gid[i]);
    if (en_e) begin
      chk($sformatf("u%0d mem_addr", i), mem_addr[i], m_adr[i]);
      chk($sformatf("u%0d mem_wdata", i), mem_wdata[i], m_dat[i]);
    end
  endtask

  task automatic env_cycle(input int i);
    if (mem_en[i]) begin
      env_en[i]  = n;
      env_adr[i] = mem_addr[i];
      if (mem_we[i]) env_mem[i][mem_addr[i][7:0]] = mem_wdata[i];
    end
    if (n == env_en[i] + lat_of(i)) mem_rdata[i] = env_mem[i][env_adr[i][7:0]];
    else                            mem_rdata[i] = 16'($urandom);
  endtask

  task automatic drive_cycle(input int i);
    for (int p = 0; p < 2; p++) begin
      if (pend[i] && (n == tack(i)) && (own[i] == p)) begin
        act[i][p]  = 1'b0;
        hold[i][p] = 1'b0;
      end
      if (act[i][p] && pend[i] && (own[i] == p) && (n >= t_iss[i]) && (n < tack(i))
          && ($urandom % 100 < p_drop)) begin
        act[i][p]  = 1'b0;
        hold[i][p] = 1'b1;
      end
      if (!act[i][p] && !hold[i][p]) begin
        if (want[i][p]) begin
          act[i][p] = 1'b1; want[i][p] = 1'b0;
          c_we[i][p] = w_we[i][p]; c_adr[i][p] = w_adr[i][p]; c_dat[i][p] = w_dat[i][p];
        end else if (hammer || ($urandom % 100 < p_new)) begin
          act[i][p]  = 1'b1;
          c_we[i][p] = 1'($urandom_range(0, 1));
          c_adr[i][p] = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
          c_dat[i][p] = 16'($urandom);
        end
      end
    end
  endtask

  task automatic predict(input int i);
    int w;
    if (pend[i] && (n > tack(i))) pend[i] = 1'b0;
    if (!pend[i] && (act[i][0] || act[i][1])) begin
      if (act[i][0] && act[i][1]) w = RR ? (m_last[i] ? 0 : 1) : 0;
      else                        w = act[i][1] ? 1 : 0;
      pend[i] = 1'b1; own[i] = w; t_iss[i] = n + 1;
      m_we[i] = c_we[i][w]; m_adr[i] = c_adr[i][w]; m_dat[i] = c_dat[i][w];
      m_gid[i] = w[0];
      if (RR) m_last[i] = w[0];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    n++;
    for (int i = 0; i < 2; i++) begin
      check_cycle(i);
      env_cycle(i);
      drive_cycle(i);
      predict(i);
    end
    if (rec_on) begin
      if (ack0[0]) rec_q0.push_back(0);
      if (ack1[0]) rec_q0.push_back(1);
      if (ack0[1]) rec_q1.push_back(0);
      if (ack1[1]) rec_q1.push_back(1);
    end
    apply();
  endtask

  task automatic post(input int p, input bit we, input logic [15:0] adr, input logic [15:0] dat);
    for (int i = 0; i < 2; i++) begin
      want[i][p] = 1'b1; w_we[i][p] = we; w_adr[i][p] = adr; w_dat[i][p] = dat;
    end
  endtask

  task automatic drain();
    bit idle;
    hammer = 1'b0; p_new = 0; p_drop = 0;
    idle = 1'b0;
    for (int k = 0; k < 80 && !idle; k++) begin
      tick();
      idle = !pend[0] && !pend[1];
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++)
          if (act[i][p] || want[i][p]) idle = 1'b0;
    end
    chk("drain_done", idle, 1'b1);
  endtask

  initial begin
    bit in_wait;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = 16'h0000;
      for (int a = 0; a < 256; a++) begin
        ref_mem[i][a] = 16'(a * 257) ^ 16'h5A5A;
        env_mem[i][a] = 16'(a * 257) ^ 16'h5A5A;
      end
    end
    model_reset();
    apply();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d rst mem_en", i), mem_en[i], 1'b0);
      chk($sformatf("u%0d rst mem_we", i), mem_we[i], 1'b0);
      chk($sformatf("u%0d rst ack0", i), ack0[i], 1'b0);
      chk($sformatf("u%0d rst ack1", i), ack1[i], 1'b0);
      chk($sformatf("u%0d rst busy", i), busy[i], 1'b0);
      chk($sformatf("u%0d rst rdata", i), rdata[i], 16'h0000);
      chk($sformatf("u%0d rst mem_addr", i), mem_addr[i], 16'h0000);
      chk($sformatf("u%0d rst mem_wdata", i), mem_wdata[i], 16'h0000);
      chk($sformatf("u%0d rst gnt_id", i), gnt_id[i], 1'b1);
    end
    reset = 1'b0;

    // contention: both requesters re-request immediately after every ack
    hammer = 1'b1; rec_on = 1'b1;
    repeat (40) tick();
    rec_on = 1'b0;
    drain();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u0 grant_seq[%0d]", k), (rec_q0.size() > k) ? rec_q0[k] : -1, RR ? (k % 2) : 0);
      chk($sformatf("u1 grant_seq[%0d]", k), (rec_q1.size() > k) ? rec_q1[k] : -1, RR ? (k % 2) : 0);
    end

    // directed read from requester 0, then a write from requester 1
    for (int i = 0; i < 2; i++) begin
      ref_mem[i][8'h10] = 16'hBEEF;
      env_mem[i][8'h10] = 16'hBEEF;
    end
    post(0, 1'b0, 16'h0010, 16'h0000);
    drain();
    chk("u0 read_beef", rdata[0], 16'hBEEF);
    chk("u1 read_beef", rdata[1], 16'hBEEF);
    post(1, 1'b1, 16'h0200, 16'h1234);
    drain();
    chk("u0 write_keeps_rdata", rdata[0], 16'hBEEF);
    chk("u1 write_keeps_rdata", rdata[1], 16'hBEEF);
    chk("u0 write_mem", env_mem[0][8'h00], 16'h1234);
    chk("u1 write_mem", env_mem[1][8'h00], 16'h1234);

    // random traffic with occasional mid-transaction request drops
    p_new = 30; p_drop = 3;
    repeat (1500) tick();
    drain();

    // reset while the MEM_LAT=3 instance waits on memory
    post(0, 1'b0, 16'h0033, 16'h0000);
    in_wait = 1'b0;
    for (int k = 0; k < 20 && !in_wait; k++) begin
      tick();
      in_wait = pend[1] && (n > t_iss[1]) && (n < tack(1));
    end
    chk("u1 reached_wait", in_wait, 1'b1);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d abort mem_en", i), mem_en[i], 1'b0);
      chk($sformatf("u%0d abort mem_we", i), mem_we[i], 1'b0);
      chk($sformatf("u%0d abort busy", i), busy[i], 1'b0);
      chk($sformatf("u%0d abort ack0", i), ack0[i], 1'b0);
      chk($sformatf("u%0d abort ack1", i), ack1[i], 1'b0);
    end
    model_reset();
    apply();
    tick();
    reset = 1'b0;
    repeat (8) tick();
    post(0, 1'b0, 16'h0010, 16'h0000);
    drain();
    chk("u0 after_reset_read", rdata[0], 16'hBEEF);
    chk("u1 after_reset_read", rdata[1], 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the data-memory address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-003 Parameter MEM_LAT, default 1, legal range 1..7, SHALL set the cycles from the mem_en cycle to mem_rdata valid.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on the posedge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 req0/req1  in  1  SHALL be the requests from the processor load/store port (0) and the loader port (1).
REQ-007 we0/we1  in  1  SHALL select write (1) or read (0) per requester.
REQ-008 addr0/addr1  in  ADDR_W  SHALL be the request addresses.
REQ-009 wdata0/wdata1  in  DATA_W  SHALL be the write data.
REQ-010 ack0/ack1  out  1  SHALL be one-cycle completion pulses.
REQ-011 rdata  out  DATA_W  SHALL be the read result, valid in the ack cycle.
REQ-012 mem_en, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W  SHALL form the single-port memory command.
REQ-013 mem_rdata  in  DATA_W  SHALL be the memory read data.
REQ-014 busy  out  1 and gnt_id  out  1  SHALL report the active transaction and its owner.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, ACK SHALL be implemented; only one transaction SHALL be in flight.
REQ-016 IDLE: if any req is high at the edge, SHALL latch the winner's we/addr/wdata, set gnt_id, and go to ISSUE; otherwise stay in IDLE.
REQ-017 ISSUE: SHALL assert mem_en for exactly one cycle with the latched command, load the wait counter with MEM_LAT, and go to WAIT.
REQ-018 WAIT: SHALL decrement the counter each cycle and capture mem_rdata when it reaches 1 for reads, then go to ACK.
REQ-019 ACK: SHALL pulse the winner's ack for one cycle, then go to IDLE; ack SHALL occur exactly MEM_LAT+1 cycles after the mem_en cycle.
REQ-020 rdata SHALL update only on reads; writes SHALL leave rdata unchanged.
REQ-021 Requesters SHALL hold req and the command stable until ack; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-022 A req dropped mid-transaction SHALL NOT abort the transaction; ack SHALL still pulse.
REQ-023 Simultaneous requests SHALL be resolved per REQ-028 or REQ-029; the loser SHALL wait, and its ack SHALL stay low.
REQ-024 busy SHALL be high in ISSUE, WAIT and ACK.
REQ-025 mem_we SHALL be low whenever mem_en is low.

Reset
REQ-026 On reset: FSM SHALL enter IDLE; mem_en, mem_we, ack0, ack1 and busy SHALL be 0; rdata, mem_addr and mem_wdata SHALL be 0; gnt_id and last_grant SHALL be 1.
REQ-027 Reset mid-transaction SHALL abort it immediately: mem_en drops asynchronously and no ack is issued.

Configuration
REQ-028 With ARB_ROUND_ROBIN_EN defined: on contention the requester not equal to last_grant SHALL win; last_grant SHALL update at each grant.
REQ-029 Without ARB_ROUND_ROBIN_EN: requester 0 SHALL always win contention, and last_grant SHALL be unused.

Structure
REQ-030 A shared package SHALL hold the FSM state encodings, the WORD width (16) and the MEM_LAT legal bounds.
REQ-031 Winner selection SHALL be a sub-module, arb_pick (inputs req0, req1, last_grant; outputs valid, winner).

Verification
REQ-032 Single read, MEM_LAT=1: req0, addr0=0x0010, mem_rdata=0xBEEF -> mem_en 1 cycle after the req edge, ack0 2 cycles later, rdata=0xBEEF.
REQ-033 Write: req1, we1=1, addr1=0x0200, wdata1=0x1234 -> mem_we=1, mem_addr=0x0200, mem_wdata=0x1234, ack1 pulse, rdata unchanged.
REQ-034 Contention with ARB_ROUND_ROBIN_EN: req0 and req1 held high -> grants 0,1,0,1; without the macro -> grants 0,0,0 while req0 stays high.
REQ-035 MEM_LAT=3 read -> ack exactly 4 cycles after mem_en; busy high throughout.
REQ-036 Assert reset in WAIT -> mem_en, busy and acks are 0 immediately; no ack after release; the next req0 is served normally.
